rr_mux_reg: RTL and testbench

- Parametrised N:1 selector with a registered output and valid/ready handshakes. Generalises the gate-level 2:1 mux.
- Selects one of N_IN requesting channels, either by round-robin arbitration or by a fixed-select mode, and captures the winner into a one-entry output register.
- Used as a register-file read/writeback steering stage where several producers share one bus.

---
 rtl/rr_mux_reg_if.sv | 31 +++
 rtl/rr_mux_reg.sv | 99 +++++++++
 tb/tb_rr_mux_reg.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rr_mux_reg_if.sv
// Handshake/bus bundle for rr_mux_reg.
//   in_valid/in_data/in_ready : N_IN request channels (channel i at [i*WIDTH +: WIDTH])
//   fixed_en/fixed_sel        : fixed-select mode control
//   out_valid/out_data/out_src/out_ready : registered output handshake
// master = upstream producers + downstream consumer side, slave = the mux.
interface rr_mux_reg_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32
);
  localparam int SEL_W = $clog2(N_IN);

  logic [N_IN-1:0]       in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_ready;
  logic                  fixed_en;
  logic [SEL_W-1:0]      fixed_sel;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, fixed_en, fixed_sel, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, fixed_en, fixed_sel, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N_IN:1 selector with a one-entry registered output.
// Picks a requesting channel by round-robin (fixed_en=0) or by fixed_sel
// (fixed_en=1) and captures it into out_data/out_src with 1-cycle latency.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : rr_mux_reg_if.slave (input channels, mode control, output handshake)
module rr_mux_reg #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  rr_mux_reg_if.slave bus
);
  localparam int SEL_W = $clog2(N_IN);

  logic [SEL_W-1:0] rr_ptr;
  logic             load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [N_IN-1:0]  ready_vec;

  // Register can accept whenever it is empty or being drained this cycle.
  assign load = !bus.out_valid || bus.out_ready;

  // Round-robin is done as two ascending passes: channels >= rr_ptr first,
  // then the wrapped-around channels < rr_ptr. Constant indices only, so an
  // out-of-range fixed_sel simply matches nothing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (bus.fixed_en) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (bus.in_valid[i] && (bus.fixed_sel == SEL_W'(i))) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!grant_valid && bus.in_valid[i] && (SEL_W'(i) >= rr_ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!grant_valid && bus.in_valid[i] && (SEL_W'(i) < rr_ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // in_ready held low throughout reset so no handshake can complete.
  always_comb begin
    ready_vec = '0;
    if (reset_n && load && grant_valid) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (grant_idx == SEL_W'(i)) begin
          ready_vec[i] = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = ready_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      rr_ptr        <= '0;
    end else if (load) begin
      if (grant_valid) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_src   <= grant_idx;
        if (!bus.fixed_en) begin
          rr_ptr <= (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (N_IN=4, WIDTH=32), channel i data = 'hA0+i.
module tb_rr_mux_reg;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  rr_mux_reg_if #(.N_IN(4), .WIDTH(32)) bus ();

  rr_mux_reg #(.N_IN(4), .WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output register holds channel src's word.
  task automatic chk_out(input string tag, input int unsigned src);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_src"},   64'(bus.out_src),   64'(src));
    chk({tag, "_data"},  64'(bus.out_data),  64'(32'hA0 + src));
  endtask

  initial begin
    int unsigned rr_exp [8];
    int unsigned sp_exp [4];
    checks = 0;
    errors = 0;

    bus.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    bus.fixed_en  = 1'b0;
    bus.fixed_sel = 2'd0;
    reset_n       = 1'b0;

    // Reset held for 3 cycles with all channels requesting
    repeat (3) tick();
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_src",   64'(bus.out_src),   64'd0);

    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'b0001);

    // Full rotation with all channels valid
    rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      chk_out("rr", rr_exp[k]);
    end

    // Sparse requests: ptr=0 -> 1, ptr=2 -> 3, ptr wraps to 0 -> 1 ...
    bus.in_valid = 4'b1010;
    #1;
    chk("sp_in_ready0", 64'(bus.in_ready), 64'b0010);
    sp_exp = '{1, 3, 1, 3};
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk_out("sp", sp_exp[k]);
    end
    chk("sp_wrap_ready", 64'(bus.in_ready), 64'b0010);

    // Backpressure: word from channel 3 must hold
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk_out("bp_hold", 3);
      chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_out("bp_refill0", 0);
    tick();
    chk_out("bp_refill1", 1);

    // Fixed mode on channel 1; rr_ptr is 2 here and must stay there
    bus.fixed_en  = 1'b1;
    bus.fixed_sel = 2'd1;
    #1;
    chk("fx_in_ready", 64'(bus.in_ready), 64'b0010);
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk_out("fx", 1);
    end

    // Fixed channel not requesting: register drains, contents hold
    bus.fixed_sel = 2'd2;
    bus.in_valid  = 4'b1011;
    #1;
    chk("fx_nog_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("fx_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("fx_drain_src",   64'(bus.out_src),   64'd1);
    chk("fx_drain_data",  64'(bus.out_data),  64'hA1);
    tick();
    chk("fx_idle_valid", 64'(bus.out_valid), 64'd0);

    // Back to round-robin: resumes at stored rr_ptr=2
    bus.fixed_en = 1'b0;
    bus.in_valid = 4'b1111;
    #1;
    chk("rs_in_ready", 64'(bus.in_ready), 64'b0100);
    tick();
    chk_out("rs0", 2);
    tick();
    chk_out("rs1", 3);

    // Async reset between edges while out_valid=1
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_out_data",  64'(bus.out_data),  64'd0);
    chk("ar_in_ready",  64'(bus.in_ready),  64'd0);
    tick();
    chk("ar_hold_valid", 64'(bus.out_valid), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("ar_rel_ready", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_out("ar_first", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
